spi_master_sequencer: RTL and testbench

Transaction sequencer for the FPGA-master half of the SPI signal unit. It accepts one request of up to 4 write bytes followed by up to 4 read bytes and drives the 1-byte master engine byte by byte: chip select, enable, SCK divider tick, MOSI byte load and MISO byte collection. It returns a single 32-bit response. It sits between the CSR/processor side and the SPI signal unit, and stays idle whenever the unit is strapped to slave mode.

---
 rtl/spi_master_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sequencer.sv
// Transaction sequencer for the SPI master engine: one request of up to 4 write
// bytes then up to 4 read bytes, answered by a single 32-bit response.
module spi_master_sequencer #(
  parameter int unsigned pDivMax  = 4,
  parameter int unsigned pCsSetup = 4,
  parameter int unsigned pCsHold  = 4
) (
  input  logic        iSysClk,
  input  logic        iSysRst,
  input  logic        iReqVld,
  output logic        oReqRdy,
  input  logic [31:0] iReqWrData,
  input  logic [2:0]  iReqWrLen,
  input  logic [2:0]  iReqRdLen,
  output logic        oRspVld,
  output logic [31:0] oRspData,
  output logic        oRspErr,
  output logic        oBusy,
  output logic [7:0]  oMWd,
  input  logic [7:0]  iMRd,
  input  logic        iMSpiIntr,
  output logic        oMSPICs,
  output logic        oSPIEn,
  output logic        oDivCke,
  input  logic        iMSSel
);

  localparam int unsigned DataW  = 32;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned LenW   = 3;
  localparam int unsigned NumW   = 4;
  localparam int unsigned MaxCnt = (pDivMax > pCsSetup)
                                 ? ((pDivMax > pCsHold) ? pDivMax : pCsHold)
                                 : ((pCsSetup > pCsHold) ? pCsSetup : pCsHold);
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] DivLast   = CntW'(pDivMax - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(pCsSetup - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(pCsHold - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, LOAD, SHIFT, CS_HOLD, RESP, ABORT
  } state_t;

  state_t            state, stateNext;
  logic [CntW-1:0]   cnt, cntNext;
  logic [NumW-1:0]   byteCnt, byteCntNext;
  logic [DataW-1:0]  wrShift, wrShiftNext;
  logic [DataW-1:0]  rdData, rdDataNext;
  logic [LenW-1:0]   wrLen, wrLenNext, rdLen, rdLenNext;
  logic [NumW-1:0]   nTotal, nReq;

  logic              reqRdyNext, rspVldNext, rspErrNext, busyNext;
  logic              csNext, spiEnNext, divCkeNext;
  logic [DataW-1:0]  rspDataNext;
  logic [ByteW-1:0]  mWdNext;

  function automatic logic [LenW-1:0] clampLen(input logic [LenW-1:0] len);
    return (len > LenW'(4)) ? LenW'(4) : len;
  endfunction

  assign nTotal = NumW'(wrLen) + NumW'(rdLen);
  assign nReq   = NumW'(clampLen(iReqWrLen)) + NumW'(clampLen(iReqRdLen));

  // Next-state, datapath and registered-output decode
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    byteCntNext = byteCnt;
    wrShiftNext = wrShift;
    rdDataNext  = rdData;
    wrLenNext   = wrLen;
    rdLenNext   = rdLen;
    reqRdyNext  = 1'b0;
    rspVldNext  = 1'b0;
    rspErrNext  = 1'b0;
    busyNext    = 1'b0;
    csNext      = 1'b1;
    spiEnNext   = 1'b0;
    divCkeNext  = 1'b0;
    rspDataNext = oRspData;
    mWdNext     = 8'hFF;

    case (state)
      IDLE: begin
        if (iReqVld && oReqRdy) begin
          wrShiftNext = iReqWrData;
          wrLenNext   = clampLen(iReqWrLen);
          rdLenNext   = clampLen(iReqRdLen);
          rdDataNext  = '0;
          byteCntNext = '0;
          cntNext     = '0;
          stateNext   = (nReq == '0) ? RESP : CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (cnt == SetupLast) begin
          cntNext   = '0;
          stateNext = LOAD;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      LOAD: begin
        cntNext   = '0;
        stateNext = SHIFT;
      end
      SHIFT: begin
        if (iMSpiIntr) begin
          if (byteCnt >= NumW'(wrLen)) rdDataNext = {rdData[23:0], iMRd};
          wrShiftNext = {wrShift[23:0], 8'hFF};
          byteCntNext = byteCnt + 1'b1;
          cntNext     = '0;
          stateNext   = (byteCntNext == nTotal) ? CS_HOLD : LOAD;
        end else begin
          cntNext = (cnt == DivLast) ? '0 : cnt + 1'b1;
        end
      end
      CS_HOLD: begin
        if (cnt == HoldLast) stateNext = RESP;
        else cntNext = cnt + 1'b1;
      end
      RESP:    stateNext = IDLE;
      ABORT:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // A slave-mode strap kills any transfer in flight
    if (iMSSel && !(state inside {IDLE, RESP, ABORT})) stateNext = ABORT;

    reqRdyNext = (stateNext == IDLE) && !iMSSel;
    busyNext   = (stateNext != IDLE);
    csNext     = !(stateNext inside {CS_SETUP, LOAD, SHIFT, CS_HOLD});
    spiEnNext  = (stateNext == SHIFT);
    divCkeNext = (stateNext == SHIFT) && (cntNext == DivLast);
    rspVldNext = (stateNext inside {RESP, ABORT});
    rspErrNext = (stateNext == ABORT);
    if (stateNext == RESP)       rspDataNext = rdDataNext;
    else if (stateNext == ABORT) rspDataNext = '0;

    // Write bytes come MSB first; the read phase clocks out idle 0xFF
    if (stateNext == LOAD)
      mWdNext = (byteCntNext < NumW'(wrLenNext)) ? wrShiftNext[31:24] : 8'hFF;
    else if (stateNext == SHIFT)
      mWdNext = oMWd;
  end

  always_ff @(posedge iSysClk) begin
    if (!iSysRst) begin
      state    <= IDLE;
      cnt      <= '0;
      byteCnt  <= '0;
      wrShift  <= '0;
      rdData   <= '0;
      wrLen    <= '0;
      rdLen    <= '0;
      oReqRdy  <= 1'b0;
      oRspVld  <= 1'b0;
      oRspErr  <= 1'b0;
      oRspData <= '0;
      oBusy    <= 1'b0;
      oMWd     <= 8'hFF;
      oMSPICs  <= 1'b1;
      oSPIEn   <= 1'b0;
      oDivCke  <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      byteCnt  <= byteCntNext;
      wrShift  <= wrShiftNext;
      rdData   <= rdDataNext;
      wrLen    <= wrLenNext;
      rdLen    <= rdLenNext;
      oReqRdy  <= reqRdyNext;
      oRspVld  <= rspVldNext;
      oRspErr  <= rspErrNext;
      oRspData <= rspDataNext;
      oBusy    <= busyNext;
      oMWd     <= mWdNext;
      oMSPICs  <= csNext;
      oSPIEn   <= spiEnNext;
      oDivCke  <= divCkeNext;
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Scoreboard bench for spi_master_sequencer with a behavioural 1-byte SPI engine
// that returns queued MISO bytes and records MOSI bytes.
module tb_spi_master_sequencer;

  logic        clk = 1'b0;
  logic        iSysRst;
  logic        iReqVld;
  logic        oReqRdy;
  logic [31:0] iReqWrData;
  logic [2:0]  iReqWrLen;
  logic [2:0]  iReqRdLen;
  logic        oRspVld;
  logic [31:0] oRspData;
  logic        oRspErr;
  logic        oBusy;
  logic [7:0]  oMWd;
  logic [7:0]  iMRd;
  logic        iMSpiIntr;
  logic        oMSPICs;
  logic        oSPIEn;
  logic        oDivCke;
  logic        iMSSel;

  spi_master_sequencer #(.pDivMax(4), .pCsSetup(4), .pCsHold(4)) dut (
    .iSysClk(clk), .iSysRst(iSysRst),
    .iReqVld(iReqVld), .oReqRdy(oReqRdy),
    .iReqWrData(iReqWrData), .iReqWrLen(iReqWrLen), .iReqRdLen(iReqRdLen),
    .oRspVld(oRspVld), .oRspData(oRspData), .oRspErr(oRspErr), .oBusy(oBusy),
    .oMWd(oMWd), .iMRd(iMRd), .iMSpiIntr(iMSpiIntr),
    .oMSPICs(oMSPICs), .oSPIEn(oSPIEn), .oDivCke(oDivCke), .iMSSel(iMSSel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          t0;
  } expRsp_t;

  expRsp_t    expQ[$];
  logic [7:0] mosiQ[$];
  logic [7:0] misoQ[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ckeCnt = 0;
  int csLowCnt = 0;
  int csFirst = -1;
  int csLast = -1;
  int bytesDone = 0;
  int pulses = 0;
  bit pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic chkResetState(input string name);
    chk({name, "_ctrl"}, 32'({oReqRdy, oRspVld, oRspErr, oBusy, oMSPICs, oSPIEn, oDivCke}),
        32'(7'b0000100));
    chk({name, "_rspdata"}, oRspData, 32'h0);
    chk({name, "_mwd"}, 32'(oMWd), 32'hFF);
  endtask

  // Response monitor: pops the scoreboard on every strobe
  initial begin
    expRsp_t e;
    forever begin
      @(negedge clk);
      if (oRspVld === 1'b1) begin
        if (expQ.size() == 0) failNow("unexpected_rsp");
        else begin
          e = expQ.pop_front();
          chk("rsp_data", oRspData, e.data);
          chk("rsp_err", 32'(oRspErr), 32'(e.err));
          if (e.lat > 0) chk("rsp_latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
        end
      end
    end
  end

  // Engine model: byte completes one cycle after the 16th SCK tick
  initial begin
    iMSpiIntr = 1'b0;
    iMRd = 8'h00;
    forever begin
      @(negedge clk);
      iMSpiIntr = 1'b0;
      if (pend) begin
        pend = 1'b0;
        iMSpiIntr = 1'b1;
        iMRd = (misoQ.size() != 0) ? misoQ.pop_front() : 8'h00;
        chk("no_cke_in_intr_cycle", 32'(oDivCke), 32'h0);
      end
      if (oDivCke === 1'b1) ckeCnt++;
      if (oSPIEn !== 1'b1) pulses = 0;
      else if (oDivCke === 1'b1) begin
        pulses++;
        if (pulses == 16) begin
          pulses = 0;
          pend = 1'b1;
          bytesDone++;
          if (mosiQ.size() == 0) failNow("unexpected_mosi_byte");
          else chk("mosi_byte", 32'(oMWd), 32'(mosiQ.pop_front()));
        end
      end
      if (oMSPICs === 1'b0) begin
        csLowCnt++;
        if (csFirst < 0) csFirst = cyc;
        csLast = cyc;
      end
    end
  end

  task automatic startTest();
    ckeCnt = 0;
    csLowCnt = 0;
    csFirst = -1;
    csLast = -1;
    bytesDone = 0;
    mosiQ.delete();
    misoQ.delete();
  endtask

  task automatic send(input logic [31:0] data, input logic [2:0] wl, input logic [2:0] rl,
                      input logic [31:0] expData, input logic expErr, input int expLat,
                      input bit expectRsp, output int t0);
    int n;
    expRsp_t e;
    iReqWrData = data;
    iReqWrLen = wl;
    iReqRdLen = rl;
    iReqVld = 1'b1;
    n = 0;
    while (oReqRdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_rdy", 32'(oReqRdy), 32'h1);
    t0 = cyc + 1;
    if (expectRsp) begin
      e.data = expData;
      e.err = expErr;
      e.lat = expLat;
      e.t0 = t0;
      expQ.push_back(e);
    end
    @(negedge clk);
    iReqVld = 1'b0;
    iReqWrData = 32'h1234_5678;
    iReqWrLen = 3'd3;
    iReqRdLen = 3'd3;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((expQ.size() != 0 || oBusy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 32'(n < 2000), 32'h1);
    chk("mosi_all_sent", 32'(mosiQ.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    failNow("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n;
    iSysRst = 1'b0;
    iReqVld = 1'b0;
    iReqWrData = '0;
    iReqWrLen = '0;
    iReqRdLen = '0;
    iMSSel = 1'b0;
    repeat (3) @(negedge clk);
    chkResetState("reset");
    iSysRst = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", 32'(oReqRdy), 32'h1);

    // Write-only, two bytes
    startTest();
    mosiQ = '{8'hA5, 8'h5A};
    misoQ = '{8'h5C, 8'h5C};
    send(32'hA55A_0000, 3'd2, 3'd0, 32'h0, 1'b0, 141, 1'b1, t0);
    waitDone();
    chk("wr2_cke_count", 32'(ckeCnt), 32'd32);

    // Write 1, read 2
    startTest();
    mosiQ = '{8'h9F, 8'hFF, 8'hFF};
    misoQ = '{8'h5C, 8'hEF, 8'h40};
    send(32'h9F00_0000, 3'd1, 3'd2, 32'h0000_EF40, 1'b0, 207, 1'b1, t0);
    waitDone();
    chk("w1r2_cs_first", 32'(csFirst - t0), 32'd0);
    chk("w1r2_cs_last", 32'(csLast - t0), 32'd205);

    // Zero length
    startTest();
    send(32'hFFFF_FFFF, 3'd0, 3'd0, 32'h0, 1'b0, 1, 1'b1, t0);
    waitDone();
    chk("zero_cs_low_cycles", 32'(csLowCnt), 32'd0);
    chk("zero_cke_count", 32'(ckeCnt), 32'd0);

    // Write length clamp
    startTest();
    mosiQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    misoQ = '{8'h5C, 8'h5C, 8'h5C, 8'h5C};
    send(32'h0102_0304, 3'd7, 3'd0, 32'h0, 1'b0, 273, 1'b1, t0);
    waitDone();
    chk("clamp_cke_count", 32'(ckeCnt), 32'd64);

    // Read length clamp, full 32-bit response
    startTest();
    mosiQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    misoQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(32'hAAAA_AAAA, 3'd0, 3'd5, 32'h1122_3344, 1'b0, 273, 1'b1, t0);
    waitDone();

    // Slave-mode abort during byte 2
    startTest();
    mosiQ = '{8'hDE};
    misoQ = '{8'h5C, 8'h5C};
    send(32'hDEAD_BEEF, 3'd4, 3'd0, 32'h0, 1'b1, 0, 1'b1, t0);
    n = 0;
    while (bytesDone < 1 && n < 200) begin @(negedge clk); n++; end
    chk("abort_byte1_done", 32'(bytesDone), 32'd1);
    repeat (5) @(negedge clk);
    chk("abort_in_shift", 32'(oSPIEn), 32'h1);
    iMSSel = 1'b1;
    @(negedge clk);
    chk("abort_cs_high", 32'(oMSPICs), 32'h1);
    chk("abort_spien_low", 32'(oSPIEn), 32'h0);
    chk("abort_cke_low", 32'(oDivCke), 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_rdy_held", 32'(oReqRdy), 32'h0);
    chk("abort_rsp_seen", 32'(expQ.size()), 32'h0);
    iMSSel = 1'b0;
    @(negedge clk);
    chk("abort_rdy_back", 32'(oReqRdy), 32'h1);

    // Reset mid-transfer, then a normal request
    startTest();
    send(32'hC3C3_0000, 3'd2, 3'd0, 32'h0, 1'b0, 0, 1'b0, t0);
    n = 0;
    while (oSPIEn !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("midrst_in_shift", 32'(oSPIEn), 32'h1);
    iSysRst = 1'b0;
    @(negedge clk);
    chkResetState("midrst");
    iSysRst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy_back", 32'(oReqRdy), 32'h1);
    startTest();
    mosiQ = '{8'h3C, 8'hFF};
    misoQ = '{8'h5C, 8'h77};
    send(32'h3C00_0000, 3'd1, 3'd1, 32'h0000_0077, 1'b0, 141, 1'b1, t0);
    waitDone();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
